// File: rtl/flash_prog_ctrl.sv
// Page-buffered flash programmer: fills a 256-byte page from the UART, then runs WREN / PP / RDSR polling.
// Optional sector erase before each 4 KB sector start is enabled by FLASH_PROG_SECTOR_ERASE_EN.
module flash_prog_ctrl #(
  parameter logic [23:0] BASE_ADDR  = 24'h000000,
  parameter int unsigned PAGE_LIMIT = 256,
  parameter int unsigned POLL_MAX   = 65535,
  parameter int unsigned CS_GAP     = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  input  logic        flush_i,
  output logic [7:0]  spi_tx_o,
  output logic        spi_start_o,
  input  logic        spi_done_i,
  input  logic [7:0]  spi_rx_i,
  output logic        flash_cs_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        error_o,
  output logic        overrun_o,
  output logic [7:0]  byte_cnt_o,
  output logic [15:0] page_cnt_o
);

  localparam int unsigned GAP_W = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;

  typedef enum logic [2:0] {
    S_FILL, S_WREN, S_PP, S_POLL, S_GAP, S_NEXT, S_FIN
`ifdef FLASH_PROG_SECTOR_ERASE_EN
    , S_SE
`endif
  } state_e;

  typedef enum logic [1:0] {P_CS, P_SEND, P_WAIT} phase_e;

  state_e             state_q, state_d, ret_q, ret_d;
  phase_e             ph_q, ph_d;
  logic [9:0]         idx_q, idx_d;
  logic [8:0]         fill_q, fill_d, fill_v;
  logic [15:0]        page_q, page_d, page_cnt_q, page_cnt_d, poll_q, poll_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic               flush_q, flush_d, cs_q, cs_d, start_q, start_d;
  logic [7:0]         tx_q, tx_d;
  logic               busy_q, busy_d, done_q, done_d, err_q, err_d, ovr_q, ovr_d;
  logic               mem_we, cmd_last;
  logic [7:0]         cmd_byte;
  logic [7:0]         mem [256];
  logic               unused_rx;
`ifdef FLASH_PROG_SECTOR_ERASE_EN
  logic               ers_q, ers_d;
`endif

  assign unused_rx = ^spi_rx_i[7:1];

  always_ff @(posedge clk_i) begin
    if (mem_we) mem[fill_q[7:0]] <= rx_data_i;
  end

  // Byte to send for the current command state and byte index
  always_comb begin
    cmd_byte = 8'h00;
    cmd_last = 1'b1;
    case (state_q)
      S_WREN: cmd_byte = 8'h06;
      S_PP: begin
        case (idx_q)
          10'd0:   cmd_byte = 8'h02;
          10'd1:   cmd_byte = page_q[15:8];
          10'd2:   cmd_byte = page_q[7:0];
          10'd3:   cmd_byte = 8'h00;
          default: cmd_byte = mem[8'(idx_q - 10'd4)];
        endcase
        cmd_last = (idx_q == 10'(fill_q) + 10'd3);
      end
      S_POLL: begin
        cmd_byte = (idx_q == 10'd0) ? 8'h05 : 8'h00;
        cmd_last = (idx_q == 10'd1);
      end
`ifdef FLASH_PROG_SECTOR_ERASE_EN
      S_SE: begin
        case (idx_q)
          10'd0:   cmd_byte = 8'h20;
          10'd1:   cmd_byte = page_q[15:8];
          10'd2:   cmd_byte = page_q[7:0];
          default: cmd_byte = 8'h00;
        endcase
        cmd_last = (idx_q == 10'd3);
      end
`endif
      default: ;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    ret_d      = ret_q;
    ph_d       = ph_q;
    idx_d      = idx_q;
    fill_d     = fill_q;
    fill_v     = fill_q;
    page_d     = page_q;
    page_cnt_d = page_cnt_q;
    poll_d     = poll_q;
    gap_d      = gap_q;
    flush_d    = flush_q;
    cs_d       = cs_q;
    start_d    = 1'b0;
    tx_d       = tx_q;
    done_d     = done_q;
    err_d      = err_q;
    ovr_d      = ovr_q;
    mem_we     = 1'b0;
`ifdef FLASH_PROG_SECTOR_ERASE_EN
    ers_d      = ers_q;
`endif

    if (rx_valid_i && !(state_q inside {S_FILL, S_FIN})) ovr_d = 1'b1;

    case (state_q)
      S_FILL: begin
        if (rx_valid_i) begin
          mem_we = 1'b1;
          fill_v = fill_q + 9'd1;
        end
        fill_d = fill_v;
        // A byte arriving with FLUSH is stored before the flush decision
        if (fill_v == 9'd256 || (flush_i && fill_v != 9'd0)) begin
          flush_d = flush_i;
          state_d = S_WREN;
          ph_d    = P_CS;
          idx_d   = 10'd0;
`ifdef FLASH_PROG_SECTOR_ERASE_EN
          ers_d   = (page_q[3:0] == 4'd0);
`endif
        end else if (flush_i) begin
          state_d = S_FIN;
          done_d  = 1'b1;
        end
      end

      S_WREN, S_PP, S_POLL
`ifdef FLASH_PROG_SECTOR_ERASE_EN
      , S_SE
`endif
      : begin
        case (ph_q)
          P_CS: begin
            cs_d = 1'b0;
            ph_d = P_SEND;
          end
          P_SEND: begin
            start_d = 1'b1;
            tx_d    = cmd_byte;
            ph_d    = P_WAIT;
          end
          default: begin
            if (spi_done_i && !cmd_last) begin
              idx_d = idx_q + 10'd1;
              ph_d  = P_SEND;
            end else if (spi_done_i) begin
              cs_d    = 1'b1;
              ph_d    = P_CS;
              idx_d   = 10'd0;
              gap_d   = '0;
              state_d = S_GAP;
              case (state_q)
                S_WREN: begin
                  ret_d = S_PP;
`ifdef FLASH_PROG_SECTOR_ERASE_EN
                  if (ers_q) ret_d = S_SE;
`endif
                end
                S_POLL: begin
                  if (spi_rx_i[0]) begin
                    poll_d = poll_q + 16'd1;
                    ret_d  = S_POLL;
                    if (17'(poll_q) + 17'd1 >= 17'(POLL_MAX)) begin
                      err_d   = 1'b1;
                      state_d = S_FIN;
                    end
                  end else begin
                    poll_d = 16'd0;
                    ret_d  = S_NEXT;
`ifdef FLASH_PROG_SECTOR_ERASE_EN
                    if (ers_q) begin
                      ers_d = 1'b0;
                      ret_d = S_WREN;
                    end
`endif
                  end
                end
                default: ret_d = S_POLL;
              endcase
            end
          end
        endcase
      end

      S_GAP: begin
        if (gap_q == GAP_W'(CS_GAP - 1)) state_d = ret_q;
        else gap_d = gap_q + GAP_W'(1);
      end

      S_NEXT: begin
        page_cnt_d = page_cnt_q + 16'd1;
        page_d     = page_q + 16'd1;
        fill_d     = 9'd0;
        flush_d    = 1'b0;
        if (flush_q || (page_cnt_q + 16'd1 == 16'(PAGE_LIMIT))) begin
          state_d = S_FIN;
          done_d  = 1'b1;
        end else begin
          state_d = S_FILL;
        end
      end

      S_FIN: cs_d = 1'b1;

      default: state_d = S_FILL;
    endcase

    busy_d = !(state_d inside {S_FILL, S_FIN});
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_FILL;
      ret_q      <= S_FILL;
      ph_q       <= P_CS;
      idx_q      <= 10'd0;
      fill_q     <= 9'd0;
      page_q     <= BASE_ADDR[23:8];
      page_cnt_q <= 16'd0;
      poll_q     <= 16'd0;
      gap_q      <= '0;
      flush_q    <= 1'b0;
      cs_q       <= 1'b1;
      start_q    <= 1'b0;
      tx_q       <= 8'h00;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      ovr_q      <= 1'b0;
`ifdef FLASH_PROG_SECTOR_ERASE_EN
      ers_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      ret_q      <= ret_d;
      ph_q       <= ph_d;
      idx_q      <= idx_d;
      fill_q     <= fill_d;
      page_q     <= page_d;
      page_cnt_q <= page_cnt_d;
      poll_q     <= poll_d;
      gap_q      <= gap_d;
      flush_q    <= flush_d;
      cs_q       <= cs_d;
      start_q    <= start_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      ovr_q      <= ovr_d;
`ifdef FLASH_PROG_SECTOR_ERASE_EN
      ers_q      <= ers_d;
`endif
    end
  end

  assign spi_tx_o    = tx_q;
  assign spi_start_o = start_q;
  assign flash_cs_o  = cs_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign error_o     = err_q;
  assign overrun_o   = ovr_q;
  assign byte_cnt_o  = fill_q[7:0];
  assign page_cnt_o  = page_cnt_q;

endmodule

// File: tb/tb_flash_prog_ctrl.sv
// Directed bench for flash_prog_ctrl with a negedge SPI engine model logging every shifted byte.
module tb_flash_prog_ctrl;

`ifdef FLASH_PROG_SECTOR_ERASE_EN
  localparam int ERS = 1;
`else
  localparam int ERS = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0, flush = 1'b0;
  logic        spi_done = 1'b0;
  logic [7:0]  spi_rx = 8'h00;
  logic [7:0]  spi_tx, byte_cnt;
  logic        spi_start, flash_cs, busy, done, error, overrun;
  logic [15:0] page_cnt;

  logic        rx_valid2 = 1'b0, flush2 = 1'b0, spi_done2 = 1'b0;
  logic [7:0]  spi_rx2 = 8'h01;
  logic [7:0]  spi_tx2, byte_cnt2;
  logic        spi_start2, flash_cs2, busy2, done2, error2, overrun2;
  logic [15:0] page_cnt2;

  flash_prog_ctrl dut (
    .clk_i(clk), .rst_ni(rst_n), .rx_data_i(rx_data), .rx_valid_i(rx_valid), .flush_i(flush),
    .spi_tx_o(spi_tx), .spi_start_o(spi_start), .spi_done_i(spi_done), .spi_rx_i(spi_rx),
    .flash_cs_o(flash_cs), .busy_o(busy), .done_o(done), .error_o(error), .overrun_o(overrun),
    .byte_cnt_o(byte_cnt), .page_cnt_o(page_cnt)
  );

  flash_prog_ctrl #(.POLL_MAX(2)) dut2 (
    .clk_i(clk), .rst_ni(rst_n), .rx_data_i(rx_data), .rx_valid_i(rx_valid2), .flush_i(flush2),
    .spi_tx_o(spi_tx2), .spi_start_o(spi_start2), .spi_done_i(spi_done2), .spi_rx_i(spi_rx2),
    .flash_cs_o(flash_cs2), .busy_o(busy2), .done_o(done2), .error_o(error2), .overrun_o(overrun2),
    .byte_cnt_o(byte_cnt2), .page_cnt_o(page_cnt2)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0] txq[$];
  logic [7:0] expq[$];
  int   dly = 0, frame_pos = 0, cs_hi_run = 0, cs_lo_run = 0, min_gap = 1000;
  int   poll_cmds = 0, starts = 0, wip_left = 0;
  logic [7:0] cur_cmd = 8'h00;
  bit   seen_frame = 0, setup_bad = 0, start_cs_bad = 0;
  int   dly2 = 0, fpos2 = 0, polls2 = 0;

  // SPI engine model: DONE eight cycles after each START, WIP answered on the RDSR dummy byte
  always @(negedge clk) begin
    spi_done = 1'b0;
    if (!rst_n) begin
      dly = 0; frame_pos = 0; cs_hi_run = 0; cs_lo_run = 0;
    end else begin
      if (dly > 0) begin
        dly--;
        if (dly == 0) spi_done = 1'b1;
      end
      if (flash_cs) begin
        cs_hi_run++; cs_lo_run = 0; frame_pos = 0;
      end else begin
        if (cs_lo_run == 0 && seen_frame && cs_hi_run < min_gap) min_gap = cs_hi_run;
        cs_hi_run = 0;
        cs_lo_run++;
      end
      if (spi_start) begin
        starts++;
        txq.push_back(spi_tx);
        if (flash_cs) start_cs_bad = 1;
        if (frame_pos == 0) begin
          cur_cmd = spi_tx; seen_frame = 1;
          if (spi_tx == 8'h05) poll_cmds++;
          if (cs_lo_run != 2) setup_bad = 1;
        end
        if (cur_cmd == 8'h05 && frame_pos == 1) begin
          spi_rx = (wip_left > 0) ? 8'h01 : 8'h00;
          if (wip_left > 0) wip_left--;
        end
        frame_pos++;
        dly = 8;
      end
    end
  end

  // Engine for the second instance: flash never leaves WIP
  always @(negedge clk) begin
    spi_done2 = 1'b0;
    if (!rst_n) begin
      dly2 = 0; fpos2 = 0;
    end else begin
      if (dly2 > 0) begin
        dly2--;
        if (dly2 == 0) spi_done2 = 1'b1;
      end
      if (flash_cs2) fpos2 = 0;
      if (spi_start2) begin
        if (fpos2 == 0 && spi_tx2 == 8'h05) polls2++;
        fpos2++;
        dly2 = 8;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; rx_valid = 1'b0; flush = 1'b0; rx_valid2 = 1'b0; flush2 = 1'b0;
    repeat (2) @(negedge clk);
    txq.delete(); expq.delete();
    poll_cmds = 0; starts = 0; wip_left = 0; polls2 = 0; cur_cmd = 8'h00;
    rst_n = 1'b1;
  endtask

  task automatic send_bytes(input logic [7:0] base, input int n, input bit flush_last);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rx_data  = 8'(base + 8'(i));
      rx_valid = 1'b1;
      flush    = flush_last && (i == n - 1);
    end
    @(negedge clk);
    rx_valid = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(busy), 32'd0);
  endtask

  task automatic add_page(input logic [15:0] pg, input logic [7:0] base, input int n);
`ifdef FLASH_PROG_SECTOR_ERASE_EN
    if (pg[3:0] == 4'd0) begin
      expq.push_back(8'h06); expq.push_back(8'h20); expq.push_back(pg[15:8]);
      expq.push_back(pg[7:0]); expq.push_back(8'h00); expq.push_back(8'h05); expq.push_back(8'h00);
    end
`endif
    expq.push_back(8'h06); expq.push_back(8'h02); expq.push_back(pg[15:8]);
    expq.push_back(pg[7:0]); expq.push_back(8'h00);
    for (int i = 0; i < n; i++) expq.push_back(8'(base + 8'(i)));
    expq.push_back(8'h05); expq.push_back(8'h00);
  endtask

  task automatic cmp_q(input string tag);
    int mism = 0;
    check({tag, "_len"}, 32'(txq.size()), 32'(expq.size()));
    for (int i = 0; i < txq.size() && i < expq.size(); i++)
      if (txq[i] !== expq[i]) mism++;
    check({tag, "_bytes"}, 32'(mism), 32'd0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int n;
    repeat (3) @(negedge clk);
    check("rst_cs", 32'(flash_cs), 32'd1);
    check("rst_start", 32'(spi_start), 32'd0);
    check("rst_tx", 32'(spi_tx), 32'd0);
    check("rst_flags", 32'({busy, done, error, overrun}), 32'd0);
    check("rst_cnts", 32'({byte_cnt, page_cnt}), 32'd0);
    rst_n = 1'b1;

    // Full page of 00..FF
    add_page(16'd0, 8'h00, 256);
    send_bytes(8'h00, 256, 1'b0);
    wait_idle("t1_idle");
    cmp_q("t1");
    check("t1_gap", 32'(min_gap >= 4), 32'd1);
    check("t1_cs_setup", 32'({setup_bad, start_cs_bad}), 32'd0);
    check("t1_page_cnt", 32'(page_cnt), 32'd1);
    check("t1_byte_cnt", 32'(byte_cnt), 32'd0);
    check("t1_done", 32'(done), 32'd0);
    check("t1_polls", 32'(poll_cmds), 32'(1 + ERS));

    // 10 bytes, FLUSH together with the last one
    do_reset();
    add_page(16'd0, 8'hA0, 10);
    send_bytes(8'hA0, 10, 1'b1);
    wait_idle("t2_idle");
    cmp_q("t2");
    check("t2_done", 32'(done), 32'd1);
    check("t2_page_cnt", 32'(page_cnt), 32'd1);
    check("t2_error", 32'(error), 32'd0);

    // Three busy polls then ready
    do_reset();
    wip_left = 3;
    send_bytes(8'h30, 5, 1'b1);
    wait_idle("t3_idle");
    check("t3_polls", 32'(poll_cmds), 32'(4 + ERS));
    check("t3_error", 32'(error), 32'd0);
    check("t3_done", 32'(done), 32'd1);

    // FLUSH on an empty buffer, then RX while finished
    do_reset();
    @(negedge clk); flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    check("t4_done", 32'(done), 32'd1);
    rx_data = 8'h99; rx_valid = 1'b1;
    @(negedge clk); rx_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("t4_starts", 32'(starts), 32'd0);
    check("t4_overrun", 32'(overrun), 32'd0);
    check("t4_cs_busy", 32'({flash_cs, busy}), 32'b10);

    // Byte dropped during PP data phase
    do_reset();
    add_page(16'd0, 8'h00, 256);
    add_page(16'd1, 8'h11, 3);
    send_bytes(8'h00, 256, 1'b0);
    n = 0;
    while (!(cur_cmd == 8'h02 && frame_pos >= 10) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("t5_reach_pp", 32'(cur_cmd == 8'h02 && frame_pos >= 10), 32'd1);
    rx_data = 8'h77; rx_valid = 1'b1;
    @(negedge clk); rx_valid = 1'b0;
    check("t5_overrun", 32'(overrun), 32'd1);
    wait_idle("t5_idle1");
    check("t5_byte_cnt", 32'(byte_cnt), 32'd0);
    check("t5_page_cnt1", 32'(page_cnt), 32'd1);
    send_bytes(8'h11, 3, 1'b1);
    wait_idle("t5_idle2");
    cmp_q("t5");
    check("t5_page_cnt2", 32'(page_cnt), 32'd2);
    check("t5_done", 32'(done), 32'd1);

    // Reset during the PP address bytes
    do_reset();
    send_bytes(8'hC0, 256, 1'b0);
    n = 0;
    while (!(cur_cmd == 8'h02 && frame_pos >= 2) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("t6_reach_addr", 32'(cur_cmd == 8'h02 && frame_pos >= 2 && frame_pos < 4), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_cs", 32'(flash_cs), 32'd1);
    check("t6_outs", 32'({spi_start, spi_tx, busy, done, error, overrun}), 32'd0);
    check("t6_cnts", 32'({byte_cnt, page_cnt}), 32'd0);
    repeat (2) @(negedge clk);
    txq.delete(); expq.delete(); poll_cmds = 0; wip_left = 0; cur_cmd = 8'h00;
    rst_n = 1'b1;
    add_page(16'd0, 8'h50, 4);
    send_bytes(8'h50, 4, 1'b1);
    wait_idle("t6_idle");
    cmp_q("t6");
    check("t6_done", 32'(done), 32'd1);

    // POLL_MAX=2 with WIP stuck high
    do_reset();
    @(negedge clk); rx_data = 8'h5A; rx_valid2 = 1'b1; flush2 = 1'b1;
    @(negedge clk); rx_valid2 = 1'b0; flush2 = 1'b0;
    n = 0;
    while (busy2 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check("t7_idle", 32'(busy2), 32'd0);
    check("t7_error", 32'(error2), 32'd1);
    check("t7_done", 32'(done2), 32'd0);
    check("t7_cs", 32'(flash_cs2), 32'd1);
    check("t7_polls", 32'(polls2), 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
